// File: rtl/y_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// y_operand_stage_pkg : shared CPU constants (datapath widths, ALU op codes)
// Rev 1.0
// ============================================================================
package y_operand_stage_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;

  // op[2] selects subtract, op[1:0] selects the ALU result mux
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

endpackage
`default_nettype wire

// File: rtl/y_regfile.sv
`default_nettype none
// ============================================================================
// y_regfile : 2-read/1-write register file, x0 hardwired to zero, write bypass
// Rev 1.0
// ============================================================================
module y_regfile
  import y_operand_stage_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_N  = 32,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0] r_mem [REG_N];
  logic              w_wr;

  assign w_wr = wb_en && (wb_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[wb_addr] <= wb_data;
    end
  end

  // Same-cycle write-back is forwarded so a reader never sees the old value
  always_comb begin
    rs1_data = r_mem[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (w_wr && (wb_addr == rs1_addr)) begin
      rs1_data = wb_data;
    end
  end

  always_comb begin
    rs2_data = r_mem[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (w_wr && (wb_addr == rs2_addr)) begin
      rs2_data = wb_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/y_operand_stage.sv
`default_nettype none
// ============================================================================
// y_operand_stage : operand fetch + single-entry pipeline register feeding ALU
// Rev 1.0
// ============================================================================
module y_operand_stage
  import y_operand_stage_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_N  = 32,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic [2:0]        alu_op,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [2:0]        op,
  output logic [ADDR_W-1:0] out_rd
);

  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;
  logic              w_accept;
  logic              w_wb_live;
  logic [ADDR_W-1:0] r_rs1;
  logic [ADDR_W-1:0] r_rs2;
  logic              r_use_imm;

  y_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (w_rs1_data),
    .rs2_data (w_rs2_data),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  assign in_ready  = !flush && (!out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_wb_live = wb_en && (wb_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      out_rd    <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_use_imm <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      a         <= w_rs1_data;
      b         <= use_imm ? imm : w_rs2_data;
      op        <= alu_op;
      out_rd    <= rd;
      r_rs1     <= rs1;
      r_rs2     <= rs2;
      r_use_imm <= use_imm;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // A write-back landing during a stall must reach the held operands
      if (w_wb_live && (wb_addr == r_rs1)) begin
        a <= wb_data;
      end
      if (w_wb_live && !r_use_imm && (wb_addr == r_rs2)) begin
        b <= wb_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y_operand_stage.sv
`default_nettype none
// ============================================================================
// tb_y_operand_stage : directed self-checking bench for y_operand_stage
// Rev 1.0
// ============================================================================
module tb_y_operand_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, use_imm, flush, wb_en, out_valid, out_ready;
  logic [4:0]  rs1, rs2, rd, wb_addr, out_rd;
  logic [31:0] imm, wb_data, a, b;
  logic [2:0]  alu_op, op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  y_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .use_imm(use_imm),
    .alu_op(alu_op), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .op(op), .out_rd(out_rd)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 0; flush = 0; wb_en = 0; out_ready = 1; use_imm = 0;
    rs1 = 0; rs2 = 0; rd = 0; imm = 0; alu_op = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic test_reset;
    idle();
    reset = 1; wb_en = 1; wb_addr = 3; wb_data = 32'd77;
    tick();
    reset = 0; wb_en = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (a !== 32'd0 || b !== 32'd0) begin n_fail++; $display("FAIL reset_ab got %h/%h want 0/0", a, b); end
    n_checks++; if (op !== 3'd0 || out_rd !== 5'd0) begin n_fail++; $display("FAIL reset_op_rd got %h/%h want 0/0", op, out_rd); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    // write issued during reset must have been ignored
    in_valid = 1; rs1 = 3; rs2 = 3; alu_op = 3'b000; rd = 4;
    tick();
    in_valid = 0;
    n_checks++; if (a !== 32'd0 || b !== 32'd0) begin n_fail++; $display("FAIL reset_wb_ignored got %h/%h want 0/0", a, b); end
    tick();
  endtask

  task automatic test_first_accept;
    in_valid = 1; rs1 = 0; rs2 = 0; alu_op = 3'b010; rd = 1; use_imm = 0;
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", out_valid); end
    n_checks++; if (a !== 32'd0 || b !== 32'd0) begin n_fail++; $display("FAIL first_ab got %h/%h want 0/0", a, b); end
    n_checks++; if (op !== 3'b010 || out_rd !== 5'd1) begin n_fail++; $display("FAIL first_op_rd got %b/%0d want 010/1", op, out_rd); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_consume got %b want 0", out_valid); end
    n_checks++; if (op !== 3'b010) begin n_fail++; $display("FAIL first_hold_op got %b want 010", op); end
  endtask

  task automatic test_bypass;
    wb_en = 1; wb_addr = 5; wb_data = 32'h0000_1234;
    in_valid = 1; rs1 = 5; rs2 = 5; use_imm = 0; alu_op = 3'b010; rd = 2;
    tick();
    wb_en = 0; in_valid = 0;
    n_checks++; if (a !== 32'h0000_1234 || b !== 32'h0000_1234) begin n_fail++; $display("FAIL bypass_ab got %h/%h want 00001234/00001234", a, b); end
    tick();
    in_valid = 1; rs1 = 5; rs2 = 0;
    tick();
    in_valid = 0;
    n_checks++; if (a !== 32'h0000_1234 || b !== 32'd0) begin n_fail++; $display("FAIL rf_read got %h/%h want 00001234/0", a, b); end
    tick();
  endtask

  task automatic test_x0;
    // x0 written in the same cycle it is read: no bypass, no storage
    wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    in_valid = 1; rs1 = 0; rs2 = 0; use_imm = 0; alu_op = 3'b001; rd = 3;
    tick();
    wb_en = 0; in_valid = 0;
    n_checks++; if (a !== 32'd0 || b !== 32'd0) begin n_fail++; $display("FAIL x0_bypass got %h/%h want 0/0", a, b); end
    tick();
    in_valid = 1; rs1 = 0; rs2 = 5; use_imm = 1; imm = 32'hFFFF_FFF6; alu_op = 3'b111; rd = 6;
    tick();
    in_valid = 0; use_imm = 0;
    n_checks++; if (a !== 32'd0) begin n_fail++; $display("FAIL x0_read got %h want 0", a); end
    n_checks++; if (b !== 32'hFFFF_FFF6) begin n_fail++; $display("FAIL imm_b got %h want fffffff6", b); end
    n_checks++; if (op !== 3'b111 || out_rd !== 5'd6) begin n_fail++; $display("FAIL slt_op got %b/%0d want 111/6", op, out_rd); end
    tick();
  endtask

  task automatic test_stall_refresh;
    wb_en = 1; wb_addr = 7; wb_data = 32'd1;
    tick();
    wb_en = 0;
    in_valid = 1; rs1 = 7; rs2 = 7; use_imm = 0; alu_op = 3'b001; rd = 7; out_ready = 0;
    tick();
    n_checks++; if (out_valid !== 1'b1 || a !== 32'd1) begin n_fail++; $display("FAIL stall_load got %b/%h want 1/1", out_valid, a); end
    rs1 = 0; rs2 = 0; alu_op = 3'b110; rd = 9;
    wb_en = 1; wb_addr = 7; wb_data = 32'd42;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    tick();
    wb_addr = 9; wb_data = 32'd500;
    n_checks++; if (a !== 32'd42 || b !== 32'd42) begin n_fail++; $display("FAIL refresh_ab got %h/%h want 2a/2a", a, b); end
    n_checks++; if (op !== 3'b001 || out_rd !== 5'd7) begin n_fail++; $display("FAIL stall_hold got %b/%0d want 001/7", op, out_rd); end
    tick();
    wb_en = 0; in_valid = 0;
    n_checks++; if (a !== 32'd42 || out_valid !== 1'b1) begin n_fail++; $display("FAIL refresh_nomatch got %h/%b want 2a/1", a, out_valid); end
    out_ready = 1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || a !== 32'd42) begin n_fail++; $display("FAIL release_once got %b/%h want 0/2a", out_valid, a); end
    // latched immediate must not be overwritten by a write to rs2
    in_valid = 1; rs1 = 0; rs2 = 7; use_imm = 1; imm = 32'd5; alu_op = 3'b000; rd = 1; out_ready = 0;
    tick();
    in_valid = 0; use_imm = 0;
    wb_en = 1; wb_addr = 7; wb_data = 32'd99;
    tick();
    wb_en = 0;
    n_checks++; if (b !== 32'd5 || a !== 32'd0) begin n_fail++; $display("FAIL imm_no_refresh got %h/%h want 0/5", a, b); end
    out_ready = 1;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops [4];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110;
    out_ready = 1; in_valid = 1; rs1 = 7; rs2 = 0; use_imm = 0;
    for (int i = 0; i < 4; i++) begin
      alu_op = ops[i]; rd = 5'(i + 1);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || op !== ops[i] || out_rd !== 5'(i + 1) || a !== 32'd99) begin
        n_fail++;
        $display("FAIL b2b_%0d got v=%b op=%b rd=%0d a=%h want 1/%b/%0d/63", i, out_valid, op, out_rd, a, ops[i], i + 1);
      end
    end
    in_valid = 0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush;
    in_valid = 1; rs1 = 7; rs2 = 0; alu_op = 3'b010; rd = 3; out_ready = 0;
    tick();
    alu_op = 3'b111; rd = 9; rs1 = 0; flush = 1;
    wb_en = 1; wb_addr = 7; wb_data = 32'd555;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    tick();
    flush = 0; in_valid = 0; wb_en = 0; out_ready = 1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
    n_checks++; if (op !== 3'b010 || out_rd !== 5'd3) begin n_fail++; $display("FAIL flush_no_capture got %b/%0d want 010/3", op, out_rd); end
    n_checks++; if (a !== 32'd99) begin n_fail++; $display("FAIL flush_over_refresh got %h want 63", a); end
    in_valid = 1; rs1 = 7; alu_op = 3'b000; rd = 2;
    tick();
    in_valid = 0;
    n_checks++; if (a !== 32'd555) begin n_fail++; $display("FAIL flush_rf_write got %h want 22b", a); end
    tick();
  endtask

  task automatic test_reset_mid_stall;
    in_valid = 1; rs1 = 5; rs2 = 0; alu_op = 3'b010; rd = 5; out_ready = 0;
    tick();
    in_valid = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    n_checks++; if (out_valid !== 1'b0 || a !== 32'd0) begin n_fail++; $display("FAIL reset_stall got %b/%h want 0/0", out_valid, a); end
    out_ready = 1; in_valid = 1; rs1 = 5;
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1 || a !== 32'd0) begin n_fail++; $display("FAIL reset_rf_clear got %b/%h want 1/0", out_valid, a); end
    tick();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_first_accept();
    test_bypass();
    test_x0();
    test_stall_refresh();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
